axi_rr_arbiter_rab: RTL
=======================

# axi_rr_arbiter_rab

Round-robin arbiter sharing one valid/ready datapath (typically the input of a RAB channel buffer) among NUM_IN upstream requesters. It grants one requester at a time, muxes its data, last flag and identity onto the single downstream port, and keeps the grant for the whole burst, until the beat with `last` is accepted. Selection is combinational (zero latency). A small state machine plus a rotating priority pointer guarantees fairness and AXI-compliant valid/data stability.

## Interface
- `NUM_IN`, default 4: number of requesters, ≥1, need not be a power of two
- `DATA_WIDTH`, default 64: payload width per requester
- `ID_WIDTH`, default max(1,$clog2(NUM_IN)): width of `out_id`, derived, not overridden
- `clk`  in  1  single clock, rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `in_valid`  in  NUM_IN  per-requester valid
- `in_data`  in  NUM_IN*DATA_WIDTH  flattened payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- `in_last`  in  NUM_IN  per-requester end-of-burst flag
- `in_ready`  out  NUM_IN  per-requester ready, at most one bit high (one-hot or zero)
- `out_valid`  out  1  downstream valid
- `out_data`  out  DATA_WIDTH  granted payload
- `out_last`  out  1  granted last flag
- `out_id`  out  ID_WIDTH  index of granted requester
- `out_ready`  in  1  downstream ready (e.g. buffer ready_out)

## Operation
- State: `IDLE` (free arbitration) and `LOCK` (grant fixed to `gnt_q`). Registers: `state`, `gnt_q` [ID_WIDTH], `rr_ptr` [ID_WIDTH].
- IDLE: `sel` = first i with in_valid[i], searching from rr_ptr upward and wrapping NUM_IN-1→0. If no requester is valid: out_valid=0, in_ready all 0, out_data/out_last/out_id take requester rr_ptr's values (don't-care).
- LOCK: `sel` = gnt_q, regardless of other requesters.
- Mux: out_valid=in_valid[sel], out_data/out_last from sel, out_id=sel, in_ready[sel]=out_ready, all other in_ready=0.
- Handshake = out_valid && out_ready.
- Transitions:
  - IDLE, handshake, out_last=1 → IDLE; rr_ptr←sel+1 (wrap).
  - IDLE, handshake, out_last=0 → LOCK; gnt_q←sel.
  - IDLE, out_valid && !out_ready → LOCK; gnt_q←sel. The stalled beat cannot be pre-empted, so data stays stable.
  - LOCK, handshake, out_last=1 → IDLE; rr_ptr←gnt_q+1 (wrap).
  - LOCK, otherwise → LOCK, with no timeout.
- Requesters must hold valid/data until ready (AXI rule). A requester dropping valid mid-burst while in LOCK stalls the port; this is legal and not an error.
- Fairness: after a burst from requester k completes, every other valid requester is served before k again.

## Timing
- Zero-cycle latency in both directions: in_valid→out_valid and out_ready→in_ready are combinational.
- No combinational path from out_ready to out_valid.
- Reset, asynchronous: state=IDLE, rr_ptr=0, gnt_q=0. While rstn=0, out_valid=0 and in_ready all 0, forced regardless of inputs. Reset mid-burst drops the lock; the next burst restarts arbitration from requester 0.
- Back-to-back single-beat bursts from different requesters sustain one beat per cycle.
- NUM_IN=1: rr_ptr and gnt_q are constant 0 and the block degenerates to a wire with stall lock.

## Configuration
- `AXI_RR_ARB_BURST_LOCK_EN`
  - Defined: behaviour as above, with the grant held until the `last` beat.
  - Not defined: in_last is ignored for arbitration. Every handshake is treated as last, so IDLE→LOCK occurs only on stall, and rr_ptr advances after every accepted beat (beat-level interleave). out_last is still forwarded.

## Structure
- Package `axi_rab_arb_pkg` holds:
  - `arb_state_e` (IDLE, LOCK)
  - a function computing ID width from NUM_IN
- Sub-module `rr_prio_pick`: purely combinational. Takes a NUM_IN request vector and the start pointer; returns `found` and `idx`. Instantiated once.

## Test plan
- Reset and idle: rstn=0 with in_valid=4'b1111 → out_valid=0, in_ready=0. After release with no requests, state=IDLE and rr_ptr=0.
- Rotation: all 4 requesters send 1-beat bursts continuously with out_ready=1 → out_id sequence 0,1,2,3,0; one beat per cycle.
- Burst lock: req 1 sends 3 beats (last on the 3rd) while req 2 is valid throughout → out_id=1,1,1, then 2. With the macro undefined, the sequence is 1,2,1,2,1.
- Stall stability: req 3 is valid with out_ready=0 for 5 cycles, then req 0 asserts → out_id stays 3 and out_data stays unchanged until out_ready=1.
- Wrap and non-power-of-two: NUM_IN=3, the grant ends at req 2 → rr_ptr=0 and the next grant goes to req 0 even if req 1 is also valid.
- Mid-burst reset: rstn pulsed low during req 2's 2nd of 4 beats → out_valid=0 immediately. After release, req 0 (valid) is granted first.

Source files
------------

// File: rtl/axi_rr_arbiter_rab_pkg.sv
// axi_rab_arb_pkg: arbitration state type and ID-width helper shared by axi_rr_arbiter_rab.
package axi_rab_arb_pkg;
  typedef enum logic {IDLE, LOCK} arb_state_e;
  function automatic int arb_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axi_rr_arbiter_rab_rr_prio_pick.sv
// rr_prio_pick: first set request at or after start, wrapping at N-1 back to 0.
module rr_prio_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);
  // Scanning from the far end lets the candidate nearest start overwrite the others.
  always_comb begin
    found_o = 1'b0;
    idx_o   = start_i;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(start_i) + k) % N]) begin
        found_o = 1'b1;
        idx_o   = W'((int'(start_i) + k) % N);
      end
    end
  end
endmodule

// File: rtl/axi_rr_arbiter_rab.sv
// axi_rr_arbiter_rab: round-robin valid/ready arbiter with zero-latency muxing and stall lock.
// Define AXI_RR_ARB_BURST_LOCK_EN to hold the grant until the last beat; otherwise beats interleave.
module axi_rr_arbiter_rab
  import axi_rab_arb_pkg::*;
#(
  parameter  int NUM_IN     = 4,
  parameter  int DATA_WIDTH = 64,
  localparam int ID_WIDTH   = arb_id_width(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_IN-1:0]            in_valid,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]            in_last,
  output logic [NUM_IN-1:0]            in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_last,
  output logic [ID_WIDTH-1:0]          out_id,
  input  logic                         out_ready
);
  arb_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] gnt_q, gnt_d, rr_ptr_q, rr_ptr_d, pick_idx, sel, sel_nxt;
  logic                found, hs, last_eff, adv;

  rr_prio_pick #(.N(NUM_IN), .W(ID_WIDTH)) u_pick (
    .req_i  (in_valid),
    .start_i(rr_ptr_q),
    .found_o(found),
    .idx_o  (pick_idx)
  );

  assign sel       = (state_q == LOCK) ? gnt_q : pick_idx;
  assign out_valid = rstn & in_valid[sel];
  assign out_data  = in_data[sel*DATA_WIDTH +: DATA_WIDTH];
  assign out_last  = in_last[sel];
  assign out_id    = sel;
  assign in_ready  = {NUM_IN{rstn & out_ready & (found | (state_q == LOCK))}} & (NUM_IN'(1) << sel);
  assign hs        = out_valid & out_ready;
`ifdef AXI_RR_ARB_BURST_LOCK_EN
  assign last_eff  = out_last;
`else
  assign last_eff  = 1'b1;
`endif
  assign sel_nxt   = (sel == ID_WIDTH'(NUM_IN - 1)) ? '0 : sel + 1'b1;
  assign adv       = hs & last_eff;
  // Any presented beat that does not end the grant pins the selection, so a stall cannot be pre-empted.
  assign state_d   = adv ? IDLE : (out_valid ? LOCK : state_q);
  assign gnt_d     = (!adv && out_valid) ? sel : gnt_q;
  assign rr_ptr_d  = adv ? sel_nxt : rr_ptr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule
